// File: rtl/pc_pkg.sv
// Shared opcode encodings for the next-PC selector.
// The fetch-stage decoder, the PC unit and the bench all import these.
package pc_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_JMP  = 3'b010;
    localparam logic [2:0] OP_BR   = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;

endpackage

// File: rtl/pc_ras_unit_if.sv
// Decoder-facing bus of the PC unit.
// The decoder side drives the control inputs and observes the PC and RAS status.
interface pc_ras_unit_if #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
);

    logic             en;
    logic [2:0]       op;
    logic             cond;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] pc;
    logic [CW-1:0]    ras_count;
    logic             ras_full;
    logic             ras_empty;
    logic             err;

    modport master (
        output en, op, cond, target, offset,
        input  pc, ras_count, ras_full, ras_empty, err
    );

    modport slave (
        input  en, op, cond, target, offset,
        output pc, ras_count, ras_full, ras_empty, err
    );

endinterface

// File: rtl/pc_ras.sv
// DEPTH x WIDTH return-address LIFO.
// A push while full and a pop while empty are silently ignored.
module pc_ras #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             doPush;
    logic             doPop;
    logic [AW-1:0]    wrIdx;
    logic [AW-1:0]    topIdx;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign wrIdx  = AW'(count_q);
    assign topIdx = AW'(count_q - CW'(1));

    always_comb begin
        count_d = count_q;
        if (doPush) begin
            count_d = count_q + CW'(1);
        end else if (doPop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrIdx] <= din;
        end
    end

    assign top   = empty ? '0 : mem_q[topIdx];
    assign count = count_q;

endmodule

// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with opcode-driven next-PC mux and return-address stack.
// Define PC_OVF_TRAP_EN to redirect the PC to TRAP_VECTOR on a RAS overflow/underflow.
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 6,
    parameter int               DEPTH        = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = '1
) (
    input logic             clk,
    input logic             rst,
    pc_ras_unit_if.slave    bus
);

`ifdef PC_OVF_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             err_q;
    logic             err_d;
    logic [WIDTH-1:0] pcPlusOne;
    logic [WIDTH-1:0] rasTop;
    logic [CW-1:0]    rasCount;
    logic             rasFull;
    logic             rasEmpty;
    logic             push;
    logic             pop;

    assign pcPlusOne = pc_q + WIDTH'(1);
    assign push      = bus.en && (bus.op == OP_CALL);
    assign pop       = bus.en && (bus.op == OP_RET);

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pcPlusOne),
        .top   (rasTop),
        .count (rasCount),
        .full  (rasFull),
        .empty (rasEmpty)
    );

    // Reserved opcodes fall into the default arm and advance like INC.
    always_comb begin
        pc_d  = pc_q;
        err_d = err_q;
        if (bus.en) begin
            case (bus.op)
                OP_HOLD: pc_d = pc_q;
                OP_JMP:  pc_d = bus.target;
                OP_BR:   pc_d = bus.cond ? (pc_q + bus.offset) : pcPlusOne;
                OP_CALL: begin
                    pc_d = bus.target;
                    if (rasFull) begin
                        err_d = 1'b1;
                        if (TrapEn) pc_d = TRAP_VECTOR;
                    end
                end
                OP_RET: begin
                    if (rasEmpty) begin
                        err_d = 1'b1;
                        pc_d  = TrapEn ? TRAP_VECTOR : pcPlusOne;
                    end else begin
                        pc_d = rasTop;
                    end
                end
                default: pc_d = pcPlusOne;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_VECTOR;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.err       = err_q;
    assign bus.ras_count = rasCount;
    assign bus.ras_full  = rasFull;
    assign bus.ras_empty = rasEmpty;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed scoreboard bench for pc_ras_unit (WIDTH=6, DEPTH=4, RESET_VECTOR=0).
// Expectations follow PC_OVF_TRAP_EN when the bench is built with it.
module tb_pc_ras_unit;
    import pc_pkg::*;

`ifdef PC_OVF_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [5:0] pc;
        logic [2:0] cnt;
        logic       err;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   vectors;
    int   miscompares;

    pc_ras_unit_if #(.WIDTH(6), .DEPTH(4)) bus ();

    pc_ras_unit #(
        .WIDTH        (6),
        .DEPTH        (4),
        .RESET_VECTOR (6'd0),
        .TRAP_VECTOR  (6'd63)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkField(input string tag, input string field,
                              input logic [7:0] got, input logic [7:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("[TB] FAIL %s.%s got %0d want %0d", tag, field, got, want);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard empty at time %0t", $time);
            return;
        end
        e = sb.pop_front();
        checkField(e.tag, "pc",    8'(bus.pc),        8'(e.pc));
        checkField(e.tag, "count", 8'(bus.ras_count), 8'(e.cnt));
        checkField(e.tag, "full",  8'(bus.ras_full),  8'(e.cnt == 3'd4));
        checkField(e.tag, "empty", 8'(bus.ras_empty), 8'(e.cnt == 3'd0));
        checkField(e.tag, "err",   8'(bus.err),       8'(e.err));
    endtask

    task automatic expectNow(input string tag, input logic [5:0] p,
                             input logic [2:0] c, input logic e);
        exp_t x;
        x.tag = tag; x.pc = p; x.cnt = c; x.err = e;
        sb.push_back(x);
    endtask

    // Drive one op, let one rising edge take it, then compare just after the edge.
    task automatic applyStimulus(input string tag, input logic e, input logic [2:0] o,
                                 input logic c, input logic [5:0] t, input logic [5:0] off,
                                 input logic [5:0] expPc, input logic [2:0] expCnt,
                                 input logic expErr);
        bus.en     = e;
        bus.op     = o;
        bus.cond   = c;
        bus.target = t;
        bus.offset = off;
        expectNow(tag, expPc, expCnt, expErr);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic pulseReset(input string tag);
        #2 rst = 1'b1;
        #1;
        expectNow(tag, 6'd0, 3'd0, 1'b0);
        checkOutput();
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [5:0] errPcCall;
        logic [5:0] errPcRet;
        logic [5:0] afterRet;
        vectors     = 0;
        miscompares = 0;
        errPcCall   = TrapEn ? 6'd63 : 6'd40;
        errPcRet    = TrapEn ? 6'd63 : 6'd10;
        afterRet    = TrapEn ? 6'd0  : 6'd11;

        rst        = 1'b1;
        bus.en     = 1'b0;
        bus.op     = OP_HOLD;
        bus.cond   = 1'b0;
        bus.target = '0;
        bus.offset = '0;
        #12;
        expectNow("reset", 6'd0, 3'd0, 1'b0);
        checkOutput();
        #1 rst = 1'b0;

        applyStimulus("inc1",   1, OP_INC, 0, 0, 0, 6'd1, 0, 0);
        applyStimulus("inc2",   1, OP_INC, 0, 0, 0, 6'd2, 0, 0);
        applyStimulus("inc3",   1, OP_INC, 0, 0, 0, 6'd3, 0, 0);
        applyStimulus("jmp63",  1, OP_JMP, 0, 6'd63, 0, 6'd63, 0, 0);
        applyStimulus("incwrap",1, OP_INC, 0, 0, 0, 6'd0, 0, 0);
        applyStimulus("jmp17",  1, OP_JMP, 0, 6'd17, 0, 6'd17, 0, 0);
        pulseReset("asyncrst");

        applyStimulus("stall1", 0, OP_JMP, 0, 6'd20, 0, 6'd0, 0, 0);
        applyStimulus("stall2", 0, OP_JMP, 0, 6'd20, 0, 6'd0, 0, 0);
        applyStimulus("stall3", 0, OP_JMP, 0, 6'd20, 0, 6'd0, 0, 0);
        applyStimulus("unstall",1, OP_JMP, 0, 6'd20, 0, 6'd20, 0, 0);

        applyStimulus("jmp10a", 1, OP_JMP, 0, 6'd10, 0, 6'd10, 0, 0);
        applyStimulus("brback", 1, OP_BR, 1, 0, 6'b111110, 6'd8, 0, 0);
        applyStimulus("jmp10b", 1, OP_JMP, 0, 6'd10, 0, 6'd10, 0, 0);
        applyStimulus("brnot",  1, OP_BR, 0, 0, 6'b111110, 6'd11, 0, 0);
        applyStimulus("jmp62",  1, OP_JMP, 0, 6'd62, 0, 6'd62, 0, 0);
        applyStimulus("brwrap", 1, OP_BR, 1, 0, 6'd3, 6'd1, 0, 0);
        applyStimulus("rsv110", 1, 3'b110, 0, 6'd40, 0, 6'd2, 0, 0);
        applyStimulus("rsv111", 1, 3'b111, 0, 6'd40, 0, 6'd3, 0, 0);
        applyStimulus("hold",   1, OP_HOLD, 1, 6'd40, 6'd5, 6'd3, 0, 0);

        applyStimulus("jmp5",   1, OP_JMP,  0, 6'd5,  0, 6'd5,  0, 0);
        applyStimulus("call20", 1, OP_CALL, 0, 6'd20, 0, 6'd20, 1, 0);
        applyStimulus("call30", 1, OP_CALL, 0, 6'd30, 0, 6'd30, 2, 0);
        applyStimulus("stallret",0, OP_RET, 0, 0, 0, 6'd30, 2, 0);
        applyStimulus("ret21",  1, OP_RET,  0, 0, 0, 6'd21, 1, 0);
        applyStimulus("ret6",   1, OP_RET,  0, 0, 0, 6'd6,  0, 0);

        applyStimulus("fill1",  1, OP_CALL, 0, 6'd8,  0, 6'd8,  1, 0);
        applyStimulus("fill2",  1, OP_CALL, 0, 6'd9,  0, 6'd9,  2, 0);
        applyStimulus("fill3",  1, OP_CALL, 0, 6'd12, 0, 6'd12, 3, 0);
        applyStimulus("fill4",  1, OP_CALL, 0, 6'd16, 0, 6'd16, 4, 0);
        applyStimulus("ovf",    1, OP_CALL, 0, 6'd40, 0, errPcCall, 4, 1);
        applyStimulus("unw13",  1, OP_RET,  0, 0, 0, 6'd13, 3, 1);
        applyStimulus("unw10",  1, OP_RET,  0, 0, 0, 6'd10, 2, 1);
        applyStimulus("unw9",   1, OP_RET,  0, 0, 0, 6'd9,  1, 1);
        applyStimulus("unw7",   1, OP_RET,  0, 0, 0, 6'd7,  0, 1);
        pulseReset("clrerr");

        applyStimulus("jmp9",   1, OP_JMP, 0, 6'd9, 0, 6'd9, 0, 0);
        applyStimulus("udf",    1, OP_RET, 0, 0, 0, errPcRet, 0, 1);
        applyStimulus("sticky", 1, OP_INC, 0, 0, 0, afterRet, 0, 1);
        pulseReset("finalrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
- Parametrised program counter, successor to the 3-bit PC: configurable width, opcode-driven next-PC selection and a return-address stack (RAS).
- Sits in the CPU fetch stage. The PC register drives instruction-memory address; the decoder supplies op/target/offset.
- Adds behaviour the 3-bit PC lacks: reset vector, stall, relative branch, call/return with a LIFO of return addresses, and error flagging.

Parameters:
- WIDTH, 6, PC/address width in bits (≥2).
- DEPTH, 4, RAS entries (≥1).
- RESET_VECTOR, 0, PC value after reset (WIDTH bits).
- TRAP_VECTOR, 2**WIDTH-1, PC target on RAS error (used only with PC_OVF_TRAP_EN).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  1 = advance per op; 0 = stall (hold all state).
- op  input  3  next-PC opcode (see Behaviour).
- cond  input  1  branch condition for BR.
- target  input  WIDTH  absolute target for JMP/CALL.
- offset  input  WIDTH  two's-complement offset for BR.
- pc  output  WIDTH  current PC, registered.
- ras_count  output  $clog2(DEPTH+1)  occupied RAS entries.
- ras_full  output  1  ras_count==DEPTH.
- ras_empty  output  1  ras_count==0.
- err  output  1  sticky RAS error flag.

Behaviour:
- Reset (async, rst=1): pc=RESET_VECTOR, ras_count=0, err=0; ras_empty=1, ras_full=0. Stored RAS data is don't-care. Reset mid-call discards all entries.
- Priority: rst > en=0 > op. With en=0, pc, the RAS and err hold regardless of op.
- All outputs are registered or derived from registers. Op takes effect at the edge; new pc is visible one cycle later (latency 1).
- Arithmetic is modulo 2^WIDTH; wrap is silent and not an error. INC from 2^WIDTH-1 gives 0.
- Opcodes (en=1):
  - 000 HOLD: pc unchanged.
  - 001 INC: pc<=pc+1.
  - 010 JMP: pc<=target.
  - 011 BR: if cond then pc<=pc+offset (signed) else pc<=pc+1.
  - 100 CALL: push pc+1, pc<=target, ras_count+1.
  - 101 RET: pc<=top entry, pop, ras_count-1.
  - 110/111 reserved: behave as INC.
- CALL when ras_full: no push, contents and count unchanged, err<=1. pc handling is defined under Optional Feature.
- RET when ras_empty: no pop, err<=1. pc handling is defined under Optional Feature.
- err is sticky once set and clears only on rst.
- Nested calls return LIFO. RET immediately after CALL returns the CALL's pc+1.

Optional Feature:
- Macro PC_OVF_TRAP_EN.
- Defined: on a RAS error (CALL when full or RET when empty), pc<=TRAP_VECTOR.
- Undefined: CALL when full still does pc<=target; RET when empty does pc<=pc+1.
- In both cases err is set and the RAS is unchanged.

Decomposition:
- Shared package pc_pkg: opcode localparams OP_HOLD, OP_INC, OP_JMP, OP_BR, OP_CALL, OP_RET. Both the decoder and the bench import them.
- Sub-module pc_ras: a DEPTH×WIDTH LIFO.
  - Inputs: clk, rst, push, pop, din.
  - Outputs: top, count, full, empty.
  - Ignores push when full and pop when empty.
- pc_ras_unit: next-PC mux plus error logic.

Test Plan (WIDTH=6, DEPTH=4, RESET_VECTOR=0):
- Reset then INC ×3 → pc 0,1,2,3. Hold pc=63, INC → pc=0, err=0. Assert rst mid-cycle → pc=0 immediately, without waiting for clk.
- en=0 with op=JMP, target=20 for 3 cycles → pc unchanged. Then en=1 → next edge pc=20.
- pc=10, BR offset=6'b111110 (−2), cond=1 → pc=8. cond=0 → pc=11. pc=62, offset=+3, cond=1 → pc=1 (wrap).
- pc=5: CALL 20, then CALL 30 from pc=20, RET, RET → pc 20, 30, 21, 6. ras_count 1, 2, 1, 0; err=0.
- Four CALLs (full=1), then a fifth CALL target=40 → ras_count stays 4, err=1.
  - Without the macro: pc=40.
  - With PC_OVF_TRAP_EN: pc=63.
  - Four RETs then unwind correctly.
- RET on an empty RAS from pc=9 → err=1, ras_count=0. Without the macro pc=10; with the macro pc=63. err stays 1 until rst.
